// File: rtl/crossbar_in_buf_if.sv
// Bundle of signals between the per-lane write sources, the input buffer,
// and the downstream N-to-M compacting crossbar.
interface crossbar_in_buf_if #(
  parameter int DATA_W = 16,
  parameter int N      = 6
);
  logic [N-1:0]      wr_valid;
  logic [DATA_W-1:0] wr_data [N];
  logic [N-1:0]      wr_ready;
  logic [N-1:0]      ireq;
  logic [DATA_W-1:0] idata [N];
  logic [N-1:0]      gnt;
  logic [N-1:0]      ovf;

  // Buffer side: takes writes, presents heads and grants.
  modport slave (
    input  wr_valid, wr_data,
    output wr_ready, ireq, idata, gnt, ovf
  );

  // Source/sink side: drives writes, observes the buffer.
  modport master (
    output wr_valid, wr_data,
    input  wr_ready, ireq, idata, gnt, ovf
  );
endinterface

// File: rtl/crossbar_in_buf.sv
// Per-lane input FIFOs in front of an N-to-M compacting crossbar. The grant
// set is computed locally with the same lowest-index-first compaction the
// crossbar uses, so only heads the crossbar will actually route are popped.
module crossbar_in_buf #(
  parameter int DATA_W = 16,
  parameter int N      = 6,
  parameter int M      = 4,
  parameter int DEPTH  = 4
) (
  input  logic             clk,
  input  logic             rst,
  crossbar_in_buf_if.slave buf_if
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(N + 1);

  logic [N-1:0] ireq;
  logic [N-1:0] wr_ready;
  logic [N-1:0] gnt;
  logic [N-1:0] ovf;

  // Fixed-priority compaction: grant the first M active lanes from lane 0 up.
  always_comb begin : grant_comb
    logic [AW-1:0] active;
    active = '0;
    gnt    = '0;
    for (int i = 0; i < N; i++) begin
      if (ireq[i]) begin
        if (active < AW'(M)) gnt[i] = 1'b1;
        active = active + AW'(1);
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              push, pop;

    // Readiness is from the registered count only; a granted full lane still
    // refuses a same-cycle write.
    assign wr_ready[gi] = (count_q < CW'(DEPTH));
    assign ireq[gi]     = (count_q != '0);
    assign push         = buf_if.wr_valid[gi] && wr_ready[gi];
    assign pop          = gnt[gi];

    // Next-state for pointers, occupancy and the sticky overflow flag.
    always_comb begin
      wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
      count_d  = count_q + CW'(push) - CW'(pop);
      ovf_d    = ovf_q | (buf_if.wr_valid[gi] & ~wr_ready[gi]);
    end

    // Lane state registers with synchronous reset.
    always_ff @(posedge clk) begin
      if (rst) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
        ovf_q    <= 1'b0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
        ovf_q    <= ovf_d;
      end
    end

    // Storage write; contents need no reset since the head is masked when empty.
    always_ff @(posedge clk) begin
      if (push && !rst) mem_q[wr_ptr_q] <= buf_if.wr_data[gi];
    end

    // Head is read from registered state only, so there is no write fall-through.
    assign buf_if.idata[gi] = ireq[gi] ? mem_q[rd_ptr_q] : '0;
    assign ovf[gi]          = ovf_q;
  end

  assign buf_if.wr_ready = wr_ready;
  assign buf_if.ireq     = ireq;
  assign buf_if.gnt      = gnt;
  assign buf_if.ovf      = ovf;
endmodule

// File: doc/crossbar_in_buf.md
Name: crossbar_in_buf

Overview:
- Per-requester input buffering stage placed directly upstream of the N-to-M compacting crossbar.
- Each of N input lanes has its own FIFO and presents its head entry to the crossbar as ireq/idata.
- Each cycle, the block computes the crossbar's grant set itself: the lowest-index active requesters, up to M of them.
- Only granted entries are popped; ungranted entries are held and re-presented the next cycle, so no data is lost to crossbar oversubscription.

Parameters:
- DATA_W, 16, payload width per lane.
- N, 6, number of input lanes (crossbar inputs).
- M, 4, number of crossbar outputs; maximum grants per cycle; 1 <= M <= N.
- DEPTH, 4, entries per lane FIFO; power of two, >= 2.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_valid  in  N  per-lane write request.
- wr_data  in  DATA_W x N (unpacked array [N])  per-lane write payload.
- wr_ready  out  N  per-lane "not full".
- ireq  out  N  per-lane "FIFO non-empty"; drives crossbar ireq.
- idata  out  DATA_W x N (unpacked array [N])  per-lane FIFO head; drives crossbar idata.
- gnt  out  N  per-lane grant; the head pops at the next edge.
- ovf  out  N  sticky per-lane overflow flag.

Behaviour:
- Reset (rst=1 at an edge):
  - All read/write pointers and counts go to 0.
  - ireq=0, gnt=0, ovf=0, wr_ready=all ones, every idata=0.
  - Stored contents are discarded. Reset asserted mid-operation takes effect at that edge regardless of pending writes or grants.
- Per-lane FIFO:
  - count ranges 0..DEPTH.
  - wr_ready[i] = (count[i] < DEPTH), combinational from registered count.
  - ireq[i] = (count[i] != 0).
  - idata[i] = head entry when ireq[i]=1, else all zeros.
- Push: wr_valid[i] && wr_ready[i] at an edge writes wr_data[i] at the write pointer and increments the pointer.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Write latency: no fall-through. Data written at edge t appears on ireq/idata in the cycle after edge t. An empty lane never bypasses a write to the output in the same cycle.
- Grant (combinational, same cycle as ireq):
  - gnt[i] = ireq[i] && (number of ireq[j]=1 for j<i) < M.
  - This is identical to the crossbar's in-order compaction: granted lane k (k-th active from lane 0) is the lane the crossbar routes to output k.
  - popcount(gnt) = min(popcount(ireq), M).
- Pop: gnt[i] at an edge advances the read pointer of lane i. The new head (or zeros, if now empty) is visible after that edge.
- Simultaneous push and pop on one lane: both occur and count is unchanged.
  - Push is accepted only if wr_ready was 1 in that cycle (count < DEPTH).
  - A full lane that is granted does not accept a same-cycle write; wr_ready is 0 that cycle, with no look-ahead.
- Overflow: wr_valid[i]=1 while wr_ready[i]=0 drops the write (no state change to FIFO i) and sets ovf[i]=1 at that edge. ovf[i] is cleared only by rst.
- Ungranted lanes hold their head stable; idata[i] must not change while ireq[i]=1 and gnt[i]=0.
- Starvation: none is guaranteed against. Fixed priority is intentional because it matches the crossbar.
- Assertions the bench must check every cycle:
  - count never exceeds DEPTH or underflows.
  - popcount(gnt) <= M.
  - gnt is a subset of ireq.

Test Plan:
- Reset, then idle with wr_valid=0 -> ireq=0, gnt=0, ovf=0, wr_ready=6'b111111, all idata=0; holds for 5 cycles.
- Single write lane 2, data 16'hBEEF at edge t -> at cycle t+1: ireq=6'b000100, idata[2]=16'hBEEF, gnt=6'b000100; after edge t+1: ireq=0, idata[2]=0.
- One write to each of lanes 0..5 (data 16'h0010+i) in one cycle -> next cycle ireq=6'b111111, gnt=6'b001111; following cycle ireq=6'b110000, gnt=6'b110000, idata[4]=16'h0014, idata[5]=16'h0015; then empty.
- Lane 0 receives 5 writes (16'h0001..16'h0005) on consecutive cycles while lanes 1..4 are kept non-empty so lane 0 is still granted each cycle -> lane 0 data pops in order 1..5.
- Lane 5 saturation: lanes 0..4 each kept non-empty and lane 5 written 5 times -> lane 5 starved (gnt[5]=0); wr_ready[5]=0 after the 4th write; the 5th write is dropped and ovf[5]=1; stop lanes 0..4 -> lane 5 drains 4 entries in order and ovf[5] stays 1.
- Wrap-around: on lane 3, push/pop 10 entries with count cycling 0..3 -> output order equals input order across pointer wrap. Then assert rst mid-burst with count=2 -> next cycle ireq[3]=0, ovf=0, wr_ready[3]=1.
